// File: rtl/seq_approx_divider_if.sv
// Operand/result handshake bundle for seq_approx_divider.
// A transfer happens on a rising clk edge where valid and ready are both high; a valid source holds its data until then.
interface seq_approx_divider_if #(
    parameter int W = 8
);
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] n;
    logic [W-1:0]   d;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   q;
    logic [W-1:0]   r;
    logic           ovf;
    logic           dz;

    modport master (
        output in_valid, n, d, out_ready,
        input  in_ready, out_valid, q, r, ovf, dz
    );

    modport slave (
        input  in_valid, n, d, out_ready,
        output in_ready, out_valid, q, r, ovf, dz
    );
endinterface

// File: rtl/seq_approx_divider.sv
// Sequential restoring divider, 2W/W -> W quotient + W remainder, ROWS_PER_CYCLE rows per clock.
// Define DIV_APPROX_EN to make rows 0..APPROX_ROWS-1 use the approximate subtractor cell.
module seq_approx_divider #(
    parameter int W              = 8,
    parameter int ROWS_PER_CYCLE = 1,
    parameter int APPROX_ROWS    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_approx_divider_if.slave  bus,
    output logic [1:0]           dbg_state
);
    localparam int IW = $clog2(W);

    if (W < 2 || ROWS_PER_CYCLE < 1 || (W % ROWS_PER_CYCLE) != 0 ||
        APPROX_ROWS < 0 || APPROX_ROWS > W) begin : g_bad_params
        $error("seq_approx_divider: W>=2, ROWS_PER_CYCLE must divide W, APPROX_ROWS in 0..W");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  n_lo_r;
    logic [W-1:0]  d_r;
    logic [W-1:0]  pr_r;
    logic [W-1:0]  q_r;
    logic [IW-1:0] row_r;
    logic          ovf_r;
    logic          dz_r;

    logic [W-1:0]  pr_nxt;
    logic [W-1:0]  q_nxt;
    logic [IW-1:0] k;
    logic [W:0]    res;
    logic          approx;
    logic          accept;
    logic          last_row;

    // One divider row: returns {quotient bit, row remainder}.
    function automatic logic [W:0] eval_row(input logic [W-1:0] pr, input logic nb,
                                            input logic [W-1:0] dv, input logic apx);
        logic [W-1:0] w;
        logic [W-1:0] diff;
        logic         bin;
        logic         bout;
        logic         qb;
        w    = {pr[W-2:0], nb};
        diff = '0;
        bin  = 1'b0;
        for (int j = 0; j < W; j++) begin
            if (apx) begin
                diff[j] = w[j] | ~bin;
                bout    = w[j] | ~bin;
            end else begin
                diff[j] = w[j] ^ dv[j] ^ bin;
                bout    = (~w[j] & dv[j]) | (~(w[j] ^ dv[j]) & bin);
            end
            bin = bout;
        end
        qb = pr[W-1] | ~bin;
        return {qb, qb ? diff : w};
    endfunction

    assign accept   = (state == IDLE) && bus.in_valid;
    assign last_row = (row_r == IW'(ROWS_PER_CYCLE - 1));

    always_comb begin
        pr_nxt = pr_r;
        q_nxt  = q_r;
        k      = '0;
        res    = '0;
        approx = 1'b0;
        for (int s = 0; s < ROWS_PER_CYCLE; s++) begin
            k = row_r - IW'(s);
`ifdef DIV_APPROX_EN
            approx = (int'(k) < APPROX_ROWS);
`else
            approx = 1'b0;
`endif
            res      = eval_row(pr_nxt, n_lo_r[k], d_r, approx);
            q_nxt[k] = res[W];
            pr_nxt   = res[W-1:0];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = RUN;
            RUN:     if (last_row) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // The first row's previous remainder is the dividend's upper half.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_lo_r <= '0;
            d_r    <= '0;
            pr_r   <= '0;
            q_r    <= '0;
            row_r  <= '0;
            ovf_r  <= 1'b0;
            dz_r   <= 1'b0;
        end else if (accept) begin
            n_lo_r <= bus.n[W-1:0];
            d_r    <= bus.d;
            pr_r   <= bus.n[2*W-1:W];
            q_r    <= '0;
            row_r  <= IW'(W - 1);
            ovf_r  <= (bus.n[2*W-1:W] >= bus.d);
            dz_r   <= (bus.d == '0);
        end else if (state == RUN) begin
            pr_r <= pr_nxt;
            q_r  <= q_nxt;
            if (!last_row) row_r <= row_r - IW'(ROWS_PER_CYCLE);
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.q         = q_r;
    assign bus.r         = pr_r;
    assign bus.ovf       = ovf_r;
    assign bus.dz        = dz_r;
    assign dbg_state     = state;
endmodule
